// File: rtl/matrix_addr_gen_pkg.sv
// Shared types and default sizing for the matrix address generator.
// Included by every file of the block via import matrix_addr_gen_pkg::*.
package matrix_addr_gen_pkg;

    localparam int DEF_LANES     = 32;
    localparam int DEF_ADDR_W    = 14;
    localparam int DEF_BEATS     = 512;
    localparam int DEF_DRAIN_CYC = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mag_state_e;

    // A run is in flight while beats are issued or the pipeline is flushing.
    function automatic logic state_is_busy(input mag_state_e s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

    function automatic logic state_accepts_start(input mag_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/mag_lane_ctr.sv
// Single-lane address register: resets to its lane index, loads base+index,
// and advances by a fixed stride. Updates on the falling clock edge.
module mag_lane_ctr
    import matrix_addr_gen_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LANE_IDX = 0,
    parameter int STEP     = DEF_LANES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr
);

    // Truncation to ADDR_W bits gives the modulo-2^ADDR_W wrap for free.
    localparam logic [ADDR_W-1:0] IDX_VAL  = ADDR_W'(LANE_IDX);
    localparam logic [ADDR_W-1:0] STEP_VAL = ADDR_W'(STEP);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            addr <= IDX_VAL;
        end else if (load) begin
            addr <= base + IDX_VAL;
        end else if (step) begin
            addr <= addr + STEP_VAL;
        end
    end

endmodule

// File: rtl/matrix_addr_gen.sv
// Matrix address generator: LANES parallel address lanes issued as BEATS
// beats per run, then DRAIN_CYC flush edges before done. Falling-edge clocked.
// Optional base input enabled by defining MATRIX_ADDR_GEN_BASE_IN_EN.
module matrix_addr_gen
    import matrix_addr_gen_pkg::*;
#(
    parameter int LANES     = DEF_LANES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int BEATS     = DEF_BEATS,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         ready,
`ifdef MATRIX_ADDR_GEN_BASE_IN_EN
    input  logic [ADDR_W-1:0]            base_addr,
`endif
    output logic [LANES*ADDR_W-1:0]      addr,
    output logic                         valid,
    output logic [$clog2(BEATS+1)-1:0]   beat_cnt,
    output logic                         busy,
    output logic                         done_n,
    output mag_state_e                   state_dbg
);

    localparam int CNT_W   = $clog2(BEATS + 1);
    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    localparam logic [CNT_W-1:0]   BEAT_LAST  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    mag_state_e          state_q;
    mag_state_e          state_d;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic [DRAIN_W-1:0]  drain_cnt_q;
    logic                load;
    logic                step;
    logic [ADDR_W-1:0]   base;

`ifdef MATRIX_ADDR_GEN_BASE_IN_EN
    assign base = base_addr;
`else
    assign base = '0;
`endif

    // Handshake: a beat transfers on the falling edge where valid && ready are
    // both high; valid never drops while a beat is pending, and addr/beat_cnt
    // are frozen while valid && !ready.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ready) begin
                    step = 1'b1;
                    if (beat_cnt_q == BEAT_LAST) begin
                        state_d = (DRAIN_CYC == 0) ? ST_DONE : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt_q <= '0;
        end else if (load) begin
            beat_cnt_q <= '0;
        end else if (step) begin
            beat_cnt_q <= beat_cnt_q + CNT_ONE;
        end
    end

    // Counts edges spent in DRAIN; held at zero everywhere else so each
    // entry into DRAIN starts a fresh count.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt_q <= '0;
        end else if (state_q != ST_DRAIN) begin
            drain_cnt_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mag_lane_ctr #(
            .ADDR_W   (ADDR_W),
            .LANE_IDX (k),
            .STEP     (LANES)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (load),
            .step  (step),
            .base  (base),
            .addr  (addr[k*ADDR_W +: ADDR_W])
        );
    end

    assign valid     = (state_q == ST_RUN);
    assign busy      = state_is_busy(state_q);
    assign done_n    = (state_q != ST_DONE);
    assign beat_cnt  = beat_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_matrix_addr_gen.sv
// Self-checking bench for matrix_addr_gen: directed runs, scoreboard of
// expected beats popped by a monitor on every accepted beat.
module tb_matrix_addr_gen;
    import matrix_addr_gen_pkg::*;

    localparam int LANES     = 32;
    localparam int ADDR_W    = 14;
    localparam int BEATS     = 512;
    localparam int DRAIN_CYC = 2;
    localparam int AW        = LANES * ADDR_W;
    localparam int CW        = $clog2(BEATS + 1);

    logic              clk = 1'b1;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              ready = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [AW-1:0]     addr;
    logic              valid;
    logic [CW-1:0]     beat_cnt;
    logic              busy;
    logic              done_n;
    mag_state_e        state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0] exp_q[$];
    logic [CW-1:0] exp_cnt_q[$];

    always #5 clk = ~clk;

    matrix_addr_gen #(
        .LANES     (LANES),
        .ADDR_W    (ADDR_W),
        .BEATS     (BEATS),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ready     (ready),
`ifdef MATRIX_ADDR_GEN_BASE_IN_EN
        .base_addr (base_addr),
`endif
        .addr      (addr),
        .valid     (valid),
        .beat_cnt  (beat_cnt),
        .busy      (busy),
        .done_n    (done_n),
        .state_dbg (state_dbg)
    );

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [ADDR_W-1:0] lane(input logic [AW-1:0] a, input int k);
        return a[k*ADDR_W +: ADDR_W];
    endfunction

    // Beat b of a run with base bs: lane k = bs + k + b*LANES, wrapped.
    function automatic logic [AW-1:0] model(input int bs, input int b);
        logic [AW-1:0] w;
        for (int k = 0; k < LANES; k++) w[k*ADDR_W +: ADDR_W] = ADDR_W'(bs + k + b * LANES);
        return w;
    endfunction

    task automatic push_run(input int bs);
        for (int b = 0; b < BEATS; b++) begin
            exp_q.push_back(model(bs, b));
            exp_cnt_q.push_back(CW'(b));
        end
    endtask

    // Start pulse; checks 1-edge start-to-valid latency and first-beat lanes.
    task automatic pulse_start(input int bs, input int lane0_exp, input int lane31_exp);
        @(posedge clk);
        base_addr = ADDR_W'(bs);
        start = 1'b1;
        ready = 1'b1;
        push_run(bs);
        #2;
        check("valid_before_load", valid, 0);
        @(posedge clk);
        start = 1'b0;
        #2;
        check("start_latency_valid", valid, 1);
        check("first_lane0", lane(addr, 0), lane0_exp);
        check("first_lane31", lane(addr, 31), lane31_exp);
    endtask

    task automatic wait_accepted(input bit toggle, input int stop_at, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (toggle) ready = ~ready;
            else ready = 1'b1;
            #2;
            if (exp_q.size() <= stop_at) break;
        end
        check("beats_accepted_in_budget", exp_q.size(), stop_at);
    endtask

    task automatic check_drain(input int bs);
        for (int d = 0; d < DRAIN_CYC; d++) begin
            @(posedge clk);
            #2;
            check("drain_valid", valid, 0);
            check("drain_busy", busy, 1);
            check("drain_done_n", done_n, 1);
            check("drain_beat_cnt", beat_cnt, BEATS);
            check("drain_addr_hold", addr, model(bs, BEATS));
        end
        @(posedge clk);
        #2;
        check("done_done_n", done_n, 0);
        check("done_busy", busy, 0);
        check("done_state", state_dbg, ST_DONE);
    endtask

    // Monitor: pops one expected beat per accepted transfer, and checks that
    // a stalled beat is still presented unchanged on the following cycle.
    initial begin
        logic [AW-1:0] held;
        logic [CW-1:0] held_cnt;
        logic          stalled;
        stalled = 1'b0;
        held = '0;
        held_cnt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset && valid) begin
                if (stalled) begin
                    check("stall_addr_hold", addr, held);
                    check("stall_cnt_hold", beat_cnt, held_cnt);
                end
                if (ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got addr %0h expected no beat", addr);
                    end else begin
                        check("beat_addr", addr, exp_q.pop_front());
                        check("beat_cnt", beat_cnt, exp_cnt_q.pop_front());
                    end
                end
                stalled  = !ready;
                held     = addr;
                held_cnt = beat_cnt;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bs;
        // Reset values.
        #1 reset = 1'b0;
        #3;
        check("rst_addr", addr, model(0, 0));
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done_n", done_n, 1);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_state", state_dbg, ST_IDLE);
        repeat (2) @(posedge clk);
        reset = 1'b1;

        // Run 1: ready held high, plus a second-beat hand check.
        pulse_start(0, 0, 31);
        @(posedge clk);
        #2;
        check("second_lane0", lane(addr, 0), 32);
        check("second_lane31", lane(addr, 31), 63);
        wait_accepted(1'b0, 0, BEATS + 20);
        check_drain(0);
        repeat (3) begin
            @(posedge clk);
            #2;
            check("done_hold", done_n, 0);
        end

        // Run 2: ready toggling every edge; base input exercised when present.
`ifdef MATRIX_ADDR_GEN_BASE_IN_EN
        bs = 16368;
        pulse_start(bs, 16368, 15);
`else
        bs = 0;
        pulse_start(bs, 0, 31);
`endif
        wait_accepted(1'b1, 0, 3 * BEATS);
        check_drain(bs);

        // Run 3: reset mid-run after 100 beats.
        pulse_start(0, 0, 31);
        wait_accepted(1'b0, BEATS - 100, BEATS);
        reset = 1'b0;
        #1;
        check("abort_addr", addr, model(0, 0));
        check("abort_valid", valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done_n", done_n, 1);
        check("abort_beat_cnt", beat_cnt, 0);
        exp_q.delete();
        exp_cnt_q.delete();
        @(posedge clk);
        #2;
        check("abort_no_done", done_n, 1);
        @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("post_reset_done_n", done_n, 1);
        check("post_reset_state", state_dbg, ST_IDLE);

        // Run 4: full run after the abort.
        pulse_start(0, 0, 31);
        wait_accepted(1'b0, 0, BEATS + 20);
        check_drain(0);

        // Run 5: start held for the whole run; restarts one edge after DONE.
        @(posedge clk);
        start = 1'b1;
        ready = 1'b1;
        push_run(0);
        @(posedge clk);
        #2;
        check("held_start_valid", valid, 1);
        wait_accepted(1'b0, 0, BEATS + 20);
        check_drain(0);
        push_run(0);
        @(posedge clk);
        start = 1'b0;
        #2;
        check("restart_done_n", done_n, 1);
        check("restart_valid", valid, 1);
        wait_accepted(1'b0, 0, BEATS + 20);
        check_drain(0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
